// File: rtl/addr8u_pkg.sv
// Shared types and constants for the redundant 8-bit unsigned adder controller.
package addr8u_pkg;
  localparam int unsigned OPW               = 8;
  localparam int unsigned MAX_RETRY_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/addr8u_core.sv
// Combinational 8+8 -> 9 bit unsigned adder; carry-out lands in bit 8.
module addr8u_core
  import addr8u_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [OPW:0]   sum
);
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
  end
endmodule

// File: rtl/addr8u_redund_ctrl.sv
// Two-requester controller that computes A+B twice on one adder (second pass with
// swapped operands), retries on disagreement and flags an error once retries run out.
module addr8u_redund_ctrl
  import addr8u_pkg::*;
#(
  parameter int unsigned MAX_RETRY = MAX_RETRY_DEFAULT,
  parameter int unsigned ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [15:0]         req_a,
  input  logic [15:0]         req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [8:0]          rsp_sum,
  output logic                rsp_err,
  output logic [ERRCNT_W-1:0] err_cnt,
  input  logic [8:0]          fi_mask
);

  state_t         state, state_nxt;
  logic           ptr;
  logic           gnt;
  logic           any_valid;
  logic [OPW-1:0] op_a, op_b;
  logic           op_id;
  logic [1:0]     retry;
  logic           retry_ok;
  logic [OPW:0]   r1;
  logic [OPW-1:0] add_a, add_b;
  logic [OPW:0]   add_sum;
  logic           match;

  addr8u_core u_core (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  always_comb begin
    any_valid = |req_valid;
    unique case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      default: gnt = ptr;
    endcase

    // Gated by rst_n so req_ready is low for the whole reset assertion.
    req_ready = '0;
    if (rst_n && state == IDLE && any_valid) req_ready[gnt] = 1'b1;

    add_a    = (state == PASS2) ? op_b : op_a;
    add_b    = (state == PASS2) ? op_a : op_b;
    match    = ((add_sum ^ fi_mask) == r1);
    retry_ok = 32'(retry) < MAX_RETRY;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_valid) state_nxt = PASS1;
      PASS1:   state_nxt = PASS2;
      PASS2:   state_nxt = (match || !retry_ok) ? RESP : PASS1;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 1'b0;
      retry     <= '0;
      err_cnt   <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= 1'b0;
      r1        <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (any_valid) begin
          op_a  <= req_a[{gnt, 3'b000} +: OPW];
          op_b  <= req_b[{gnt, 3'b000} +: OPW];
          op_id <= gnt;
          retry <= '0;
        end
        PASS1: r1 <= add_sum;
        PASS2: begin
          if (match || !retry_ok) begin
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            rsp_sum   <= r1;
            rsp_err   <= !match;
            if (!match && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end else begin
            retry <= retry + 2'd1;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          ptr       <= ~ptr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/addr8u_redund_ctrl.md
ADDR8U_REDUND_CTRL -- requirements
Module: addr8u_redund_ctrl

Interface
REQ-001 Parameter: MAX_RETRY, 2, number of re-executions allowed after a mismatch before an error response (range 0..3).
REQ-002 Parameter: ERRCNT_W, 8, width of the saturating error counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-006 Port: req_ready  output  2  per-requester accept; at most one bit high in any cycle.
REQ-007 Port: req_a  input  16  operand A, requester i on bits [8i+7:8i], unsigned.
REQ-008 Port: req_b  input  16  operand B, same packing as req_a.
REQ-009 Port: rsp_valid  output  1  response available.
REQ-010 Port: rsp_ready  input  1  consumer accepts response.
REQ-011 Port: rsp_id  output  1  requester index owning the response.
REQ-012 Port: rsp_sum  output  9  A+B, bit 8 = carry-out.
REQ-013 Port: rsp_err  output  1  retries exhausted; rsp_sum unverified.
REQ-014 Port: err_cnt  output  ERRCNT_W  count of rsp_err responses, saturating.
REQ-015 Port: fi_mask  input  9  test-only; XORed into the adder result during PASS2 only; tie to 0 in mission mode.

Function
REQ-016 States SHALL be IDLE, PASS1, PASS2, RESP; one shared adder instance serves both requesters and both passes.
REQ-017 IDLE: req_ready[g] SHALL be high combinationally for the granted requester g only; the accept edge SHALL latch A, B, g into operand registers, clear the retry counter, go to PASS1.
REQ-018 Arbitration: if one req_valid is high, grant it; if both, grant the round-robin pointer; pointer SHALL toggle to the other requester on each response handshake.
REQ-019 PASS1: adder inputs (A,B); result registered into r1; next state PASS2.
REQ-020 PASS2: adder inputs (B,A) (swapped operands); result XOR fi_mask compared with r1.
REQ-021 Match: next state RESP with rsp_sum=r1, rsp_err=0.
REQ-022 Mismatch with retry count < MAX_RETRY: increment retry count, next state PASS1.
REQ-023 Mismatch with retry count = MAX_RETRY: next state RESP with rsp_sum=r1, rsp_err=1; err_cnt increments, holds at all-ones.
REQ-024 Latency: accept at edge T, rsp_valid high after edge T+2 with no mismatch; each retry adds 2 cycles; worst case 2*(MAX_RETRY+1).
REQ-025 RESP: rsp_valid, rsp_id, rsp_sum, rsp_err SHALL be registered and stable until rsp_ready high at a rising edge; that edge returns to IDLE.
REQ-026 req_ready SHALL be 0 in PASS1, PASS2, RESP; requests are never accepted back-to-back with a pending response (no bypass from RESP to PASS1).
REQ-027 Sum width: 9 bits, no truncation; 255+255 SHALL yield 0x1FE.
REQ-028 req_a/req_b changes after accept SHALL not affect the in-flight operation.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, pointer=0, retry=0, err_cnt=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_err=0, req_ready=0.
REQ-030 Reset mid-operation SHALL abort the operation with no response; first grant after release follows pointer=0.

Structure
REQ-031 Package addr8u_pkg SHALL hold the state enum, operand width constant (8), and default MAX_RETRY.
REQ-032 Sub-module addr8u_core (combinational 8+8->9 unsigned adder) SHALL be instantiated exactly once.

Verification
REQ-033 Req0 A=0x3C, B=0x05, fi_mask=0 -> rsp_valid 2 cycles after accept, rsp_id=0, rsp_sum=0x041, rsp_err=0.
REQ-034 Both valid from reset, req1 A=0xFF,B=0xFF -> req0 granted first, then req1; second rsp_sum=0x1FE, rsp_id=1.
REQ-035 fi_mask=0x001 held, MAX_RETRY=2 -> rsp after 6 cycles, rsp_err=1, err_cnt=1.
REQ-036 fi_mask=0x100 for first PASS2 only -> one retry, rsp after 4 cycles, rsp_err=0, err_cnt unchanged.
REQ-037 rsp_ready low 5 cycles -> outputs stable, req_ready=0 throughout; rst_n low in PASS2 -> rsp_valid=0, state IDLE, no response.
